// File: rtl/i2c_cfg_pkg.sv
// Shared I2C configuration types: arbiter FSM states, transfer word width,
// slave addresses and the round-robin distance helper.
package i2c_cfg_pkg;

  localparam int I2C_WORD_W = 24;

  localparam logic [7:0] VIDEO_ADDR = 8'h40;
  localparam logic [7:0] AUDIO_ADDR = 8'h34;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_END,
    ST_REARM,
    ST_DONE
  } arb_state_e;

  // Steps from the round-robin pointer to requester j, wrapping at n.
  function automatic int rr_dist(input int j, input int ptr, input int n);
    return (j >= ptr) ? (j - ptr) : (j - ptr + n);
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Controller clock divider: counter 0..DIV_MAX, toggles o_ctrl_clk on wrap and
// strobes o_tick on the wrap cycle where o_ctrl_clk rises.
module i2c_tick_gen #(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_ctrl_clk,
  output logic o_tick
);

  localparam int DIV_MAX = CLK_FREQ / I2C_FREQ;
  localparam int CNT_W   = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_ctrl_clk;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(DIV_MAX));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_ctrl_clk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt      <= '0;
      r_ctrl_clk <= ~r_ctrl_clk;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_ctrl_clk = r_ctrl_clk;
  assign o_tick     = w_wrap & ~r_ctrl_clk;

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C_Controller among NUM_REQ register writers,
// with NACK retry. Define I2C_ARB_TIMEOUT_EN to add the WAIT_END tick timeout.
module i2c_cmd_arbiter
  import i2c_cfg_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int CLK_FREQ  = 50000000,
  parameter int I2C_FREQ  = 20000,
  parameter int MAX_RETRY = 3
`ifdef I2C_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_TICKS = 64
`endif
) (
  input  logic                          iCLK,
  input  logic                          iRST_N,
  input  logic [NUM_REQ-1:0]            iREQ,
  input  logic [I2C_WORD_W*NUM_REQ-1:0] iREQ_DATA,
  output logic [NUM_REQ-1:0]            oDONE,
  output logic [NUM_REQ-1:0]            oERR,
  output logic                          oBUSY,
  output logic                          oCTRL_CLK,
  output logic [I2C_WORD_W-1:0]         oI2C_DATA,
  output logic                          oI2C_GO,
  input  logic                          iI2C_END,
  input  logic                          iI2C_ACK
);

  localparam int PTR_W   = 2;
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  arb_state_e              r_state;
  logic [PTR_W-1:0]        r_rr_ptr;
  logic [PTR_W-1:0]        r_gnt;
  logic [NUM_REQ-1:0]      r_gnt_oh;
  logic [I2C_WORD_W-1:0]   r_data;
  logic [RETRY_W-1:0]      r_retry;
  logic                    r_err;

  logic                    w_tick;
  logic                    w_gnt_found;
  logic [PTR_W-1:0]        w_gnt_idx;
  logic [NUM_REQ-1:0]      w_gnt_oh;
  logic [I2C_WORD_W-1:0]   w_gnt_data;
  int                      w_best;
  logic                    w_attempt_end;
  logic                    w_nack;

  i2c_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .I2C_FREQ (I2C_FREQ)
  ) u_tick_gen (
    .i_clk      (iCLK),
    .i_rst_n    (iRST_N),
    .o_ctrl_clk (oCTRL_CLK),
    .o_tick     (w_tick)
  );

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_gnt_oh    = '0;
    w_gnt_data  = '0;
    w_best      = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (iREQ[j] && (rr_dist(j, int'(r_rr_ptr), NUM_REQ) < w_best)) begin
        w_best      = rr_dist(j, int'(r_rr_ptr), NUM_REQ);
        w_gnt_found = 1'b1;
        w_gnt_idx   = PTR_W'(j);
        w_gnt_oh    = '0;
        w_gnt_oh[j] = 1'b1;
        w_gnt_data  = iREQ_DATA[j*I2C_WORD_W +: I2C_WORD_W];
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  logic [TO_W-1:0] r_to_cnt;

  // A silent controller is treated as a NACK once the tick budget runs out.
  assign w_attempt_end = iI2C_END || (r_to_cnt == TO_W'(TIMEOUT_TICKS - 1));
  assign w_nack        = iI2C_END ? iI2C_ACK : 1'b1;
`else
  assign w_attempt_end = iI2C_END;
  assign w_nack        = iI2C_ACK;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_gnt     <= '0;
      r_gnt_oh  <= '0;
      r_data    <= '0;
      r_retry   <= '0;
      r_err     <= 1'b0;
      oI2C_DATA <= '0;
      oI2C_GO   <= 1'b0;
      oDONE     <= '0;
      oERR      <= '0;
      oBUSY     <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      r_to_cnt  <= '0;
`endif
    end else begin
      oDONE <= '0;
      oERR  <= '0;
      // DONE runs at iCLK rate so the pulse is exactly one iCLK wide.
      if (r_state == ST_DONE) begin
        oDONE    <= r_gnt_oh;
        oERR     <= r_err ? r_gnt_oh : '0;
        r_rr_ptr <= (r_gnt == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
        oBUSY    <= 1'b0;
        r_state  <= ST_IDLE;
      end else if (w_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (w_gnt_found) begin
              r_gnt    <= w_gnt_idx;
              r_gnt_oh <= w_gnt_oh;
              r_data   <= w_gnt_data;
              r_retry  <= '0;
              r_err    <= 1'b0;
              oBUSY    <= 1'b1;
              r_state  <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            oI2C_DATA <= r_data;
            oI2C_GO   <= 1'b1;
            r_state   <= ST_WAIT_END;
`ifdef I2C_ARB_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
          end
          ST_WAIT_END: begin
            if (w_attempt_end) begin
              oI2C_GO <= 1'b0;
              if (!w_nack) begin
                r_state <= ST_DONE;
              end else if (r_retry < RETRY_W'(MAX_RETRY)) begin
                r_retry <= r_retry + 1'b1;
                r_state <= ST_REARM;
              end else begin
                r_err   <= 1'b1;
                r_state <= ST_DONE;
              end
            end
`ifdef I2C_ARB_TIMEOUT_EN
            else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
`endif
          end
          ST_REARM: r_state <= ST_LOAD;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Self-checking bench for i2c_cmd_arbiter: directed cases plus randomized
// request rounds checked against a transaction-level round-robin/retry model.
module tb_i2c_cmd_arbiter;
  import i2c_cfg_pkg::*;

  localparam int NUM_REQ    = 2;
  localparam int CLK_FREQ   = 8;
  localparam int I2C_FREQ   = 2;
  localparam int MAX_RETRY  = 2;
  localparam int END_LAT    = 2;
  localparam int TB_TIMEOUT = 4;
  localparam int BUDGET     = 3000;

  typedef struct {
    int          req;
    logic [23:0] data;
    int          nacks;
  } xfer_t;

  logic                 iCLK = 1'b0;
  logic                 iRST_N = 1'b0;
  logic [NUM_REQ-1:0]   iREQ;
  logic [24*NUM_REQ-1:0] iREQ_DATA;
  logic [NUM_REQ-1:0]   oDONE, oERR;
  logic                 oBUSY, oCTRL_CLK, oI2C_GO;
  logic [23:0]          oI2C_DATA;
  logic                 iI2C_END = 1'b0;
  logic                 iI2C_ACK = 1'b0;

  xfer_t exp_q[$];
  int    ptr_m;
  bit    no_end;
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 iCLK = ~iCLK;

  i2c_cmd_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .CLK_FREQ  (CLK_FREQ),
    .I2C_FREQ  (I2C_FREQ),
    .MAX_RETRY (MAX_RETRY)
`ifdef I2C_ARB_TIMEOUT_EN
    , .TIMEOUT_TICKS (TB_TIMEOUT)
`endif
  ) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iREQ      (iREQ),
    .iREQ_DATA (iREQ_DATA),
    .oDONE     (oDONE),
    .oERR      (oERR),
    .oBUSY     (oBUSY),
    .oCTRL_CLK (oCTRL_CLK),
    .oI2C_DATA (oI2C_DATA),
    .oI2C_GO   (oI2C_GO),
    .iI2C_END  (iI2C_END),
    .iI2C_ACK  (iI2C_ACK)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int attempts_for(input int nacks);
    return (nacks > MAX_RETRY) ? MAX_RETRY + 1 : nacks + 1;
  endfunction

  // Controller model and completion scoreboard, sampled on the falling edge.
  logic prev_cc, go_prev;
  int   go_hi, go_pulses, attempt;
  bit   prev_done;
  always @(negedge iCLK) begin : mon
    xfer_t e;
    if (!iRST_N) begin
      prev_cc = 1'b0; go_prev = 1'b0; go_hi = 0; go_pulses = 0; attempt = 0;
      prev_done = 1'b0; iI2C_END = 1'b0; iI2C_ACK = 1'b0;
    end else begin
      if (prev_done) check("done_one_cycle", 32'({oDONE, oERR}), 0);
      prev_done = (oDONE != '0);
      if (oDONE != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(oDONE), 0);
        end else begin
          e = exp_q.pop_front();
          check("done_req", 32'(oDONE), 32'(1 << e.req));
          check("err_flag", 32'(oERR), (e.nacks > MAX_RETRY) ? 32'(1 << e.req) : 0);
          check("go_pulses", go_pulses, attempts_for(e.nacks));
        end
        go_pulses = 0;
        attempt   = 0;
      end
      if (oCTRL_CLK && !prev_cc) begin
        if (oI2C_GO) begin
          if (!go_prev) begin
            go_pulses++;
            go_hi = 0;
            check("busy_during_go", 32'(oBUSY), 1);
            if (exp_q.size() > 0) check("go_data", 32'(oI2C_DATA), 32'(exp_q[0].data));
          end
          go_hi++;
          if (!no_end && go_hi == END_LAT) begin
            iI2C_END = 1'b1;
            iI2C_ACK = (exp_q.size() > 0) && (attempt < exp_q[0].nacks);
            attempt++;
          end
        end else begin
          if (go_prev) check("go_high_ticks", go_hi, no_end ? TB_TIMEOUT : END_LAT);
          iI2C_END = 1'b0;
        end
        go_prev = oI2C_GO;
      end
      prev_cc = oCTRL_CLK;
    end
  end

  // Model: all requests in mask are pending together, so they are served in
  // cyclic order starting at the round-robin pointer.
  task automatic raise(input logic [1:0] mask, input logic [23:0] d0, input logic [23:0] d1,
                       input int n0, input int n1);
    int last = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int r = (ptr_m + k) % NUM_REQ;
      if (mask[r]) begin
        xfer_t e;
        e.req   = r;
        e.data  = (r == 0) ? d0 : d1;
        e.nacks = (r == 0) ? n0 : n1;
        exp_q.push_back(e);
        last = r;
      end
    end
    if (last >= 0) ptr_m = (last + 1) % NUM_REQ;
    iREQ_DATA = {d1, d0};
    iREQ      = mask;
  endtask

  task automatic wait_all();
    int cyc = 0;
    while ((exp_q.size() != 0 || iREQ != '0) && cyc < BUDGET) begin
      @(negedge iCLK);
      cyc++;
      iREQ = iREQ & ~oDONE;
    end
    check("xfer_in_budget", 32'(cyc >= BUDGET), 0);
    if (cyc >= BUDGET) begin
      exp_q.delete();
      iREQ = '0;
    end
  endtask

  task automatic apply_reset();
    @(negedge iCLK);
    iRST_N = 1'b0;
    iREQ   = '0;
    repeat (2) @(negedge iCLK);
    exp_q.delete();
    ptr_m  = 0;
    iRST_N = 1'b1;
  endtask

  function automatic logic [23:0] rand_word();
    return {($urandom_range(0, 1) != 0) ? VIDEO_ADDR : AUDIO_ADDR, 16'($urandom)};
  endfunction

  initial begin
    int cyc;
    logic [1:0] mask;
    iREQ = '0; iREQ_DATA = '0; no_end = 1'b0; ptr_m = 0;
    repeat (3) @(negedge iCLK);
    check("rst_ctrl_clk", 32'(oCTRL_CLK), 0);
    check("rst_go",       32'(oI2C_GO), 0);
    check("rst_data",     32'(oI2C_DATA), 0);
    check("rst_done",     32'(oDONE), 0);
    check("rst_err",      32'(oERR), 0);
    check("rst_busy",     32'(oBUSY), 0);
    iRST_N = 1'b1;

    // Single write, ACKed first time.
    raise(2'b01, {VIDEO_ADDR, 16'h0880}, 24'h0, 0, 0);
    wait_all();

    // Simultaneous requests from reset, then both re-raised.
    apply_reset();
    raise(2'b11, 24'h400101, 24'h340202, 0, 0);
    wait_all();
    raise(2'b11, 24'h400303, 24'h340404, 0, 0);
    wait_all();

    // Two NACKs then ACK; then NACK on every attempt.
    raise(2'b01, 24'h401122, 24'h0, 2, 0);
    wait_all();
    raise(2'b01, 24'h403344, 24'h0, 3, 0);
    wait_all();

    // Request withdrawn and data changed right after grant.
    raise(2'b10, 24'h0, 24'h345566, 0, 1);
    cyc = 0;
    while (!oBUSY && cyc < BUDGET) begin @(negedge iCLK); cyc++; end
    check("grant_seen", 32'(oBUSY), 1);
    iREQ      = '0;
    iREQ_DATA = {24'hFFFFFF, 24'hFFFFFF};
    wait_all();

`ifdef I2C_ARB_TIMEOUT_EN
    no_end = 1'b1;
    raise(2'b01, 24'h407788, 24'h0, MAX_RETRY + 1, 0);
    wait_all();
    no_end = 1'b0;
`endif

    // Reset during WAIT_END, then the pending r1 wins with the pointer at 0.
    apply_reset();
    iREQ_DATA = {24'h34AAAA, 24'h40BBBB};
    iREQ      = 2'b11;
    cyc = 0;
    while (!oI2C_GO && cyc < BUDGET) begin @(negedge iCLK); cyc++; end
    check("go_before_reset", 32'(oI2C_GO), 1);
    iRST_N = 1'b0;
    #1;
    check("async_rst_go",   32'(oI2C_GO), 0);
    check("async_rst_busy", 32'(oBUSY), 0);
    check("async_rst_cclk", 32'(oCTRL_CLK), 0);
    repeat (3) begin
      @(negedge iCLK);
      check("no_pulse_in_reset", 32'({oDONE, oERR}), 0);
    end
    exp_q.delete();
    ptr_m = 0;
    raise(2'b10, 24'h40BBBB, 24'h34AAAA, 0, 0);
    iRST_N = 1'b1;
    wait_all();

    // Randomized rounds.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 15)) @(negedge iCLK);
      mask = 2'($urandom_range(1, 3));
      raise(mask, rand_word(), rand_word(),
            $urandom_range(0, MAX_RETRY + 1), $urandom_range(0, MAX_RETRY + 1));
      wait_all();
    end

    repeat (30) @(negedge iCLK);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
